// File: rtl/instruction_loader.sv
// Byte-stream loader: packs little-endian words into instruction RAM and holds the core in reset meanwhile.
// Optional trailer checksum when LOADER_CHECKSUM_EN is defined.
// state   | meaning
// IDLE    | waiting for start_i
// COLLECT | accepting data bytes of the current word
// WRITE   | one-cycle RAM write strobe
// CHECK   | accepting the checksum trailer byte (LOADER_CHECKSUM_EN only)
// DONE    | one-cycle completion pulse
module instruction_loader #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-2:0] len_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o,
  output logic [31:0]           wr_data_o,
  output logic                  busy_o,
  output logic                  cpu_rst_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_WRITE   = 3'd2;
  localparam logic [2:0] S_CHECK   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] S_TAIL = S_CHECK;
`else
  localparam logic [2:0] S_TAIL = S_DONE;
`endif

  localparam logic [ADDR_WIDTH-2:0] MAX_LEN = {1'b1, {(ADDR_WIDTH-2){1'b0}}};
  localparam logic [ADDR_WIDTH-2:0] ONE     = {{(ADDR_WIDTH-2){1'b0}}, 1'b1};

  logic [2:0]            state;
  logic [ADDR_WIDTH-2:0] len_q;
  logic [ADDR_WIDTH-2:0] len_clamped;
  logic [ADDR_WIDTH-3:0] idx_q;
  logic [ADDR_WIDTH-2:0] idx_next;
  logic [1:0]            byte_cnt;
  logic [23:0]           word_q;
  logic                  accept;

  assign len_clamped  = (len_i > MAX_LEN) ? MAX_LEN : len_i;
  assign idx_next     = {1'b0, idx_q} + ONE;
  assign byte_ready_o = (state == S_COLLECT) || (state == S_CHECK);
  assign accept       = byte_valid_i & byte_ready_o;
  assign wr_en_o      = (state == S_WRITE);
  assign done_o       = (state == S_DONE);
  assign busy_o       = (state != S_IDLE);
  assign cpu_rst_o    = busy_o;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic       err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      byte_cnt  <= '0;
      word_q    <= '0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            len_q    <= len_clamped;
            idx_q    <= '0;
            byte_cnt <= '0;
            word_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= '0;
            err_q    <= 1'b0;
`endif
            state    <= (len_clamped == '0) ? S_TAIL : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q    <= sum_q + byte_i;
`endif
            case (byte_cnt)
              2'd0: word_q[7:0]   <= byte_i;
              2'd1: word_q[15:8]  <= byte_i;
              2'd2: word_q[23:16] <= byte_i;
              default: begin
                wr_data_o <= {byte_i, word_q};
                wr_addr_o <= {idx_q, 2'b00};
                state     <= S_WRITE;
              end
            endcase
          end
        end
        S_WRITE: begin
          // idx_q wraps only on the final word, where it is never used again
          idx_q <= idx_next[ADDR_WIDTH-3:0];
          state <= (idx_next == len_q) ? S_TAIL : S_COLLECT;
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            err_q <= ((sum_q + byte_i) != 8'd0);
            state <= S_DONE;
          end
        end
`endif
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// Scoreboard bench for instruction_loader: driver pushes expected writes/done results, a negedge monitor pops and compares.
// Honours LOADER_CHECKSUM_EN to exercise the trailer checksum path.
module tb_instruction_loader;
  localparam int AW        = 8;
  localparam int MAX_WORDS = 1 << (AW - 2);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          start_i = 1'b0;
  logic [AW-2:0] len_i = '0;
  logic [7:0]    byte_i = '0;
  logic          byte_valid_i = 1'b0;
  logic          byte_ready_o, wr_en_o, busy_o, cpu_rst_o, done_o, err_o;
  logic [AW-1:0] wr_addr_o;
  logic [31:0]   wr_data_o;

  instruction_loader #(.ADDR_WIDTH(AW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .len_i(len_i),
    .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .busy_o(busy_o), .cpu_rst_o(cpu_rst_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_wr[$];
  logic       exp_err[$];
  logic [7:0] fixed_q[$];
  int         checks = 0;
  int         errors = 0;
  int         wr_seen = 0;
  int         done_seen = 0;
  bit         done_pending = 0;
  logic       hold_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk_i) begin : monitor
    wr_t  e;
    logic ee;
    if (!rst_i) begin
      if (done_pending) begin
        check("post_done_pulse", done_o, 0);
        check("post_done_busy", busy_o, 0);
        done_pending = 0;
      end
      if (wr_en_o) begin
        wr_seen++;
        check("ready_low_in_write", byte_ready_o, 0);
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write actual=addr_%h required=no_write", wr_addr_o);
        end else begin
          e = exp_wr.pop_front();
          check("wr_addr", wr_addr_o, e.addr);
          check("wr_data", wr_data_o, e.data);
        end
      end
      if (done_o) begin
        done_seen++;
        done_pending = 1;
        if (exp_err.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done actual=done required=no_done");
        end else begin
          ee = exp_err.pop_front();
          check("done_err", err_o, ee);
          hold_err = ee;
        end
      end else if (!busy_o) begin
        check("idle_err_hold", err_o, hold_err);
      end
    end
  end

  task automatic idle(input int gap_mode);
    int g;
    g = (gap_mode == 1) ? 1 : (gap_mode == 2) ? $urandom_range(0, 2) : 0;
    repeat (g) begin @(posedge clk_i); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    byte_i = b;
    byte_valid_i = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk_i);
      if (byte_ready_o) begin ok = 1; break; end
    end
    if (ok) begin @(posedge clk_i); #1; end
    byte_valid_i = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout actual=never_ready required=ready");
    end
  endtask

  task automatic send_word(input int w, input int gap_mode, inout int sum);
    logic [31:0] word = '0;
    logic [7:0]  b;
    wr_t         e;
    for (int k = 0; k < 4; k++) begin
      idle(gap_mode);
      b = (fixed_q.size() > 0) ? fixed_q.pop_front() : 8'($urandom);
      word = word | (32'(b) << (8 * k));
      sum += int'(b);
      send_byte(b);
    end
    e.addr = 8'(w * 4);
    e.data = word;
    exp_wr.push_back(e);
    @(negedge clk_i);
    check("write_latency", wr_en_o, 1);
    check("ready_low_after_4th", byte_ready_o, 0);
  endtask

  task automatic wait_done(input int target);
    bit ok = 0;
    for (int c = 0; c < 2000; c++) begin
      if (done_seen >= target) begin ok = 1; break; end
      @(posedge clk_i); #1;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=%0d required=%0d", done_seen, target);
    end
  endtask

  task automatic do_start(input int len, input int eff);
`ifndef LOADER_CHECKSUM_EN
    exp_err.push_back(1'b0);
`endif
    start_i = 1'b1;
    len_i = 7'(len);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(negedge clk_i);
    check("busy_after_start", busy_o, 1);
    check("cpu_rst_after_start", cpu_rst_o, 1);
`ifdef LOADER_CHECKSUM_EN
    check("ready_after_start", byte_ready_o, 1);
    check("err_cleared_on_start", err_o, 0);
`else
    check("ready_after_start", byte_ready_o, 32'(eff > 0));
    check("len0_done_latency", done_o, 32'(eff == 0));
`endif
    @(posedge clk_i); #1;
  endtask

  task automatic session(input int len, input int gap_mode, input int trl_mode);
    int eff, sum, wr_base, target;
    eff = (len > MAX_WORDS) ? MAX_WORDS : len;
    sum = 0;
    wr_base = wr_seen;
    target = done_seen + 1;
    do_start(len, eff);
    for (int w = 0; w < eff; w++) send_word(w, gap_mode, sum);
`ifdef LOADER_CHECKSUM_EN
    begin
      logic [7:0] t;
      t = (trl_mode == 0) ? 8'(-sum) : (trl_mode == 1) ? 8'h00 : 8'($urandom);
      exp_err.push_back(((sum + int'(t)) % 256) != 0);
      idle(gap_mode);
      send_byte(t);
    end
`else
    if (trl_mode < 0) $display("unused trailer mode");
`endif
    wait_done(target);
    check("write_count", wr_seen - wr_base, eff);
  endtask

  task automatic reset_abort();
    int sum = 0;
    int wr_base;
    wr_base = wr_seen;
    do_start(3, 3);
    send_word(0, 0, sum);
    send_byte(8'hAA);
    send_byte(8'hBB);
    #2 rst_i = 1'b1;
    #1;
    check("abort_wr_en", wr_en_o, 0);
    check("abort_ready", byte_ready_o, 0);
    check("abort_busy", busy_o, 0);
    check("abort_cpu_rst", cpu_rst_o, 0);
    check("abort_done", done_o, 0);
    check("abort_err", err_o, 0);
    check("abort_addr", wr_addr_o, 0);
    check("abort_data", wr_data_o, 0);
    exp_wr.delete();
    exp_err.delete();
    hold_err = 1'b0;
    done_pending = 0;
    repeat (2) begin @(posedge clk_i); #1; end
    rst_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    check("abort_write_count", wr_seen - wr_base, 1);
  endtask

  initial begin
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_wr_en", wr_en_o, 0);
    check("rst_ready", byte_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cpu_rst", cpu_rst_o, 0);
    check("rst_done", done_o, 0);
    check("rst_err", err_o, 0);
    check("rst_addr", wr_addr_o, 0);
    check("rst_data", wr_data_o, 0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    fixed_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    session(2, 0, 0);
    fixed_q = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    session(2, 1, 0);
    session(0, 0, 0);
    reset_abort();
    fixed_q = '{8'h6F, 8'h00, 8'h00, 8'h00};
    session(1, 0, 0);
    session(100, 0, 0);
    session(127, 2, 0);
`ifdef LOADER_CHECKSUM_EN
    fixed_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    session(1, 0, 0);
    fixed_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    session(1, 0, 1);
    repeat (5) begin @(posedge clk_i); #1; end
`endif
    for (int i = 0; i < 10; i++)
      session($urandom_range(0, 20), $urandom_range(0, 2), $urandom_range(0, 2));

    repeat (3) begin @(posedge clk_i); #1; end
    check("wr_queue_drained", exp_wr.size(), 0);
    check("done_queue_drained", exp_err.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_loader.md
# instruction_loader

Writer side of the instruction memory interface: receives a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and writes them into the instruction RAM at consecutive word-aligned byte addresses from 0x00. It sits between the host link (UART/JTAG byte front-end) and the instruction memory write port. While loading, it holds the core in reset, so the fetch path reads only a complete program.

## Interface
- ADDR_WIDTH, 8, byte address width of the instruction memory; MAX_WORDS = 2^(ADDR_WIDTH-2)
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  begin load session; sampled only in IDLE
- len_i  in  ADDR_WIDTH-1  number of words to load; sampled with start_i
- byte_i  in  8  incoming byte
- byte_valid_i  in  1  byte_i valid
- byte_ready_o  out  1  loader accepts a byte this cycle
- wr_en_o  out  1  instruction memory write strobe, one cycle per word
- wr_addr_o  out  ADDR_WIDTH  byte address, word-aligned
- wr_data_o  out  32  assembled instruction word
- busy_o  out  1  session in progress
- cpu_rst_o  out  1  core reset request; equals busy_o
- done_o  out  1  one-cycle pulse at session end
- err_o  out  1  checksum error (see Configuration)

## Operation
- States: IDLE, COLLECT, WRITE, CHECK (macro only), DONE.
- IDLE: start_i=1 latches len_i, clamped to MAX_WORDS, and clears the word index, byte counter and checksum. Go to COLLECT if len>0, otherwise DONE. Clear err_o on start.
- COLLECT: byte_ready_o=1. A byte is accepted on an edge where byte_valid_i & byte_ready_o. Byte k (0..3) goes to bits [8k+7:8k]. After the 4th byte, go to WRITE.
- WRITE: wr_en_o=1 for one cycle, wr_addr_o = index<<2, wr_data_o = assembled word. Increment the index. If index+1 == len, go to CHECK (macro) or DONE. Otherwise go to COLLECT.
- CHECK: byte_ready_o=1. Accept one checksum byte, then go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o = state != IDLE. start_i while busy is ignored.
- No byte is accepted outside COLLECT/CHECK: byte_ready_o=0 in WRITE, DONE and IDLE.
- Address arithmetic is unsigned. The index never exceeds MAX_WORDS-1, so addresses never wrap.
- wr_addr_o and wr_data_o are registered. Outside WRITE they hold their last value. wr_en_o is the only qualifier.

## Timing
- Reset values: all outputs 0, state IDLE, internal counters and data 0.
- Reset mid-session: immediate abort. No write occurs and the partial word is discarded. Words already written remain in memory.
- Start accepted at edge N: byte_ready_o=1 from cycle N+1, or done_o=1 in cycle N+1 when len=0.
- 4th byte accepted at edge M: wr_en_o=1 in cycle M+1, byte_ready_o=0 in cycle M+1, byte_ready_o=1 again in M+2 if words remain.
- Last write in cycle W: done_o in cycle W+1 (no macro). With the macro, the checksum byte is accepted at edge C and done_o=1 in cycle C+1.
- Back-to-back valid: peak throughput is 4 bytes per 5 cycles. Gaps in byte_valid_i only stall; they never change the result.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - An 8-bit running sum covers every accepted data byte.
  - The CHECK state consumes one trailer byte.
  - err_o is set in DONE if (sum + trailer) mod 256 != 0, and is held until the next accepted start or reset.
  - len=0 still passes through CHECK.
- Not defined: no CHECK state, no trailer byte, err_o tied 0.

## Test plan
- len=2, bytes 13 05 00 00 93 05 10 00 -> write addr 0x00 data 0x00000513, write addr 0x04 data 0x00100593, done_o for exactly 1 cycle, busy_o/cpu_rst_o low the cycle after.
- Same stream with byte_valid_i asserted every other cycle -> identical two writes, no extra wr_en_o, no bytes dropped.
- len=0 -> done_o one cycle after start (no macro), wr_en_o never high.
- rst_i asserted after 2 bytes of word 1 (len=3, word 0 written) -> outputs 0 immediately, no write for word 1. A new start with len=1, bytes 6F 00 00 00 -> write addr 0x00 data 0x0000006F.
- len=100 (ADDR_WIDTH=8) -> exactly 64 writes, last at addr 0xFC, then done_o.
- LOADER_CHECKSUM_EN, len=1, bytes 01 02 03 04 + trailer F6 -> err_o=0. The same data with trailer 00 -> err_o=1, held until the next start.
